// File: rtl/fpu_pkg.sv
// Shared FPU definitions used by the finv reciprocal sequencer.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL_A = 3'd1,
    ST_ADD   = 3'd2,
    ST_MUL_X = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] CONST_TWO         = 32'h4000_0000;
  localparam logic [7:0]  EXP_RECIP_BIAS    = 8'd253;
  localparam logic [7:0]  EXP_UNDERFLOW_MIN = 8'd253;

endpackage

// File: rtl/fadd.sv
// Combinational single-precision add, round-to-nearest-even with guard/round/sticky bits.
// Denormal inputs are treated as zero; out-of-range results saturate to inf or flush to zero.
module fadd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [31:0] big;
  logic [31:0] sml;
  logic [26:0] mb;
  logic [26:0] ms;
  logic [53:0] wide;
  logic [26:0] al;
  logic [27:0] sum;
  logic [26:0] norm;
  logic [23:0] mr;
  logic [22:0] frac;
  logic        sub;
  int          dsh;
  int          lead;
  int          e;

  always_comb begin
    if (a[30:0] < b[30:0]) begin
      big = b;
      sml = a;
    end else begin
      big = a;
      sml = b;
    end
    sub = big[31] ^ sml[31];
    mb  = {1'b1, big[22:0], 3'b000};
    ms  = {1'b1, sml[22:0], 3'b000};
    dsh = int'(big[30:23]) - int'(sml[30:23]);
    if (dsh > 31) dsh = 31;
    wide = {ms, 27'd0} >> dsh;
    // Bits shifted below the round position collapse into one sticky bit.
    al   = {wide[53:28], wide[27] | (|wide[26:0])};
    sum  = sub ? ({1'b0, mb} - {1'b0, al}) : ({1'b0, mb} + {1'b0, al});
    lead = 0;
    for (int i = 0; i < 28; i++) begin
      if (sum[i]) lead = i;
    end
    if (lead == 27) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = int'(big[30:23]) + 1;
    end else begin
      norm = 27'(sum << (26 - lead));
      e    = int'(big[30:23]) - (26 - lead);
    end
    mr = {1'b0, norm[25:3]} + 24'(norm[2] & ((|norm[1:0]) | norm[3]));
    if (mr[23]) begin
      e    = e + 1;
      frac = 23'd0;
    end else begin
      frac = mr[22:0];
    end
    if (big[30:23] == 8'hFF) begin
      y = {big[31], 8'hFF, 23'd0};
    end else if (big[30:23] == 8'd0) begin
      y = 32'd0;
    end else if (sml[30:23] == 8'd0) begin
      y = big;
    end else if (!norm[26]) begin
      y = 32'd0;
    end else if (e >= 255) begin
      y = {big[31], 8'hFF, 23'd0};
    end else if (e <= 0) begin
      y = {big[31], 31'd0};
    end else begin
      y = {big[31], 8'(e), frac};
    end
  end

endmodule

// File: rtl/fmul.sv
// Combinational single-precision multiply, round-to-nearest-even.
// Denormal inputs are treated as zero; out-of-range results saturate to inf or flush to zero.
module fmul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        sgn;
  logic [47:0] prod;
  logic [22:0] mant;
  logic        g;
  logic        st;
  logic [23:0] mr;
  logic [22:0] frac;
  int          e;

  always_comb begin
    sgn  = a[31] ^ b[31];
    prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (prod[47]) begin
      mant = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
      e    = int'(a[30:23]) + int'(b[30:23]) - 126;
    end else begin
      mant = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
      e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    end
    mr = {1'b0, mant} + 24'(g & (st | mant[0]));
    if (mr[23]) begin
      e    = e + 1;
      frac = 23'd0;
    end else begin
      frac = mr[22:0];
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      y = {sgn, 31'd0};
    end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF || e >= 255) begin
      y = {sgn, 8'hFF, 23'd0};
    end else if (e <= 0) begin
      y = {sgn, 31'd0};
    end else begin
      y = {sgn, 8'(e), frac};
    end
  end

endmodule

// File: rtl/finv_seq.sv
// Newton-Raphson reciprocal x' = x*(2 - s*x), sharing one fmul and one fadd across iterations.
module finv_seq
  import fpu_pkg::*;
#(
  parameter int ITER = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] s,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] d,
  output logic        overflow,
  output logic        underflow
);

  state_e      state_q, state_d;
  logic [31:0] s_q, s_d;
  logic [31:0] x_q, x_d;
  logic [31:0] t_q, t_d;
  logic [2:0]  iter_q, iter_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [31:0] mul_a, mul_y, add_y;

  assign mul_a = (state_q == ST_MUL_X) ? t_q : s_q;

  fmul u_fmul (.a(mul_a), .b(x_q), .y(mul_y));
  fadd u_fadd (.a(CONST_TWO), .b(t_q), .y(add_y));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    x_d     = x_q;
    t_d     = t_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          s_d    = s;
          iter_d = 3'd0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (s[30:23] == 8'd0) begin
            x_d     = {s[31], 8'hFF, 23'd0};
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else if (s[30:23] >= EXP_UNDERFLOW_MIN) begin
            x_d     = {s[31], 31'd0};
            unf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Seed exponent mirrors the operand's; s*x0 lands in [0.5, 1).
            x_d     = {s[31], EXP_RECIP_BIAS - s[30:23], 23'd0};
            state_d = ST_MUL_A;
          end
        end
      end
      ST_MUL_A: begin
        t_d     = {~mul_y[31], mul_y[30:0]};
        state_d = ST_ADD;
      end
      ST_ADD: begin
        t_d     = add_y;
        state_d = ST_MUL_X;
      end
      ST_MUL_X: begin
        x_d = mul_y;
        if (iter_q == 3'(ITER - 1)) begin
          state_d = ST_DONE;
        end else begin
          iter_d  = iter_q + 3'd1;
          state_d = ST_MUL_A;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers carry no reset; outputs are gated by the DONE state instead.
  always_ff @(posedge clk) begin
    s_q    <= s_d;
    x_q    <= x_d;
    t_q    <= t_d;
    iter_q <= iter_d;
    ovf_q  <= ovf_d;
    unf_q  <= unf_d;
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign d          = resp_valid ? x_q : 32'd0;
  assign overflow   = resp_valid & ovf_q;
  assign underflow  = resp_valid & unf_q;

endmodule

// File: tb/tb_finv_seq.sv
// Table-driven bench for finv_seq with a scoreboard queue and backpressure/reset sequences.
module tb_finv_seq;

  localparam int ITER  = 6;
  localparam int LAT_N = 3 * ITER + 1;

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    logic        ovf;
    logic        unf;
    int          lat;
    int          tol;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] s;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] d;
  logic        overflow;
  logic        underflow;

  int   n_tests;
  int   n_fail;
  vec_t sb[$];
  vec_t vecs[16];

  finv_seq #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .s(s),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .d(d),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk_resp(input string name, input vec_t e, input int lat);
    logic [31:0] diff;
    diff = (d > e.d) ? (d - e.d) : (e.d - d);
    chk({name, " latency"}, lat == e.lat, 32'(lat), 32'(e.lat));
    chk({name, " d"}, diff <= 32'(e.tol), d, e.d);
    chk({name, " overflow"}, overflow == e.ovf, {31'd0, overflow}, {31'd0, e.ovf});
    chk({name, " underflow"}, underflow == e.unf, {31'd0, underflow}, {31'd0, e.unf});
  endtask

  // Drive one request, wait for the response and score it; leaves resp_valid held if hold=1.
  task automatic run_op(input vec_t v, input string name, input bit hold);
    int   n;
    vec_t e;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " req_ready"}, req_ready == 1'b1, {31'd0, req_ready}, 32'd1);
    s         = v.s;
    req_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
    e = sb.pop_front();
    chk_resp(name, e, n);
    if (!hold) begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] held;
    int          seen;
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    s          = 32'd0;

    vecs[0]  = '{32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0, LAT_N, 0};
    vecs[1]  = '{32'hC080_0000, 32'hBE80_0000, 1'b0, 1'b0, LAT_N, 0};
    vecs[2]  = '{32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, LAT_N, 1};
    vecs[3]  = '{32'h8000_0000, 32'hFF80_0000, 1'b1, 1'b0, 1, 0};
    vecs[4]  = '{32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1, 0};
    vecs[5]  = '{32'h40A0_0000, 32'h3E4C_CCCD, 1'b0, 1'b0, LAT_N, 1};
    vecs[6]  = '{32'h40E0_0000, 32'h3E12_4925, 1'b0, 1'b0, LAT_N, 1};
    vecs[7]  = '{32'h4120_0000, 32'h3DCC_CCCD, 1'b0, 1'b0, LAT_N, 1};
    vecs[8]  = '{32'hC040_0000, 32'hBEAA_AAAB, 1'b0, 1'b0, LAT_N, 1};
    vecs[9]  = '{32'h0080_0000, 32'h7E80_0000, 1'b0, 1'b0, LAT_N, 0};
    vecs[10] = '{32'h7E00_0000, 32'h0100_0000, 1'b0, 1'b0, LAT_N, 0};
    vecs[11] = '{32'h7E80_0000, 32'h0000_0000, 1'b0, 1'b1, 1, 0};
    vecs[12] = '{32'h0000_0001, 32'h7F80_0000, 1'b1, 1'b0, 1, 0};
    vecs[13] = '{32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b1, 1, 0};
    vecs[14] = '{32'hFFC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1, 0};
    vecs[15] = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, LAT_N, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", req_ready == 1'b1, {31'd0, req_ready}, 32'd1);
    chk("reset resp_valid", resp_valid == 1'b0, {31'd0, resp_valid}, 32'd0);
    chk("reset d", d == 32'd0, d, 32'd0);
    chk("reset flags", {overflow, underflow} == 2'b00, {30'd0, overflow, underflow}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Backpressure: response must hold steady while the consumer stalls.
    run_op(vecs[2], "bp", 1'b1);
    held = d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp d stable", d == held, d, held);
      chk("bp req_ready low", req_ready == 1'b0, {31'd0, req_ready}, 32'd0);
      chk("bp resp_valid held", resp_valid == 1'b1, {31'd0, resp_valid}, 32'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp release resp_valid", resp_valid == 1'b0, {31'd0, resp_valid}, 32'd0);
    chk("bp release req_ready", req_ready == 1'b1, {31'd0, req_ready}, 32'd1);

    // Reset in flight: accept at edge 0, reset sampled at edge 7, operation dropped.
    s         = 32'h4040_0000;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst mid resp_valid", resp_valid == 1'b0, {31'd0, resp_valid}, 32'd0);
    chk("rst mid req_ready", req_ready == 1'b1, {31'd0, req_ready}, 32'd1);
    chk("rst mid d", d == 32'd0, d, 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rst dropped response", seen == 0, 32'(seen), 32'd0);

    run_op(vecs[0], "after rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
